// File: rtl/mem_reader_pkg.sv
// mem_reader_pkg: shared types and defaults for the on-chip memory stream reader.
package mem_reader_pkg;
  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;
  localparam int DEPTH_DEF  = 32036;
  localparam int CREDITS    = 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/mem_reader_fifo2.sv
// mem_reader_fifo2: 2-entry registered FIFO; push and pop may coincide when non-empty.
module mem_reader_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o
);
  logic [1:0][DATA_W-1:0] mem_q;
  logic                   rd_q, wr_q;
  logic [1:0]             cnt_q;
  logic                   do_pop, do_push;
  assign do_pop  = pop_i && cnt_q != 2'd0;
  assign do_push = push_i && (cnt_q != 2'd2 || do_pop);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader: sequential word reads from on-chip memory presented as a sop/eop stream.
// Define MEM_READER_CHECKSUM_EN to add a running 32-bit checksum of streamed words.
module onchip_mem_stream_reader
  import mem_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop
`ifdef MEM_READER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);
  localparam int SW = (ADDR_W > CNT_W ? ADDR_W : CNT_W) + 2;
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  rem_q, total_q, popped_q;
  logic              inflight_q, busy_q, done_q, error_q;
  logic [1:0]        fifo_cnt;
  logic              pop, issue, too_big;
  logic [SW-1:0]     span;
  mem_reader_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (inflight_q),
    .data_i  (mem_readdata),
    .pop_i   (pop),
    .data_o  (out_data),
    .count_o (fifo_cnt)
  );
  assign out_valid      = fifo_cnt != 2'd0;
  assign pop            = out_valid && out_ready;
  // credit: words buffered plus the read in flight, less the word leaving now
  assign issue          = state_q == RUN &&
                          ({1'b0, fifo_cnt} + {2'b0, inflight_q}) < (3'(CREDITS) + {2'b0, pop});
  assign span           = SW'(base_addr) + SW'(word_count);
  assign too_big        = span > SW'(DEPTH);
  assign out_sop        = out_valid && popped_q == '0;
  assign out_eop        = out_valid && popped_q == total_q - CNT_W'(1);
  assign mem_chipselect = issue;
  assign mem_address    = addr_q;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      total_q    <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      inflight_q <= issue;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      if (pop) popped_q <= popped_q + CNT_W'(1);
      if (issue) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - CNT_W'(1);
      end
      case (state_q)
        IDLE: if (start) begin
          if (word_count == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (too_big) begin
            error_q <= 1'b1;
          end else begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            addr_q   <= base_addr;
            rem_q    <= word_count;
            total_q  <= word_count;
            popped_q <= '0;
          end
        end
        RUN:   if (issue && rem_q == CNT_W'(1)) state_q <= DRAIN;
        DRAIN: if (pop && out_eop) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef MEM_READER_CHECKSUM_EN
  logic [31:0] sum_q;
  assign checksum = sum_q;
  always_ff @(posedge clk) begin
    if (reset) sum_q <= '0;
    else if (state_q == IDLE && start && !too_big) sum_q <= '0;
    else if (pop) sum_q <= sum_q + out_data[31:0];
  end
`endif
endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// tb_onchip_mem_stream_reader: directed bench for the on-chip memory stream reader.
module tb_onchip_mem_stream_reader;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int CW = 16;
  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          busy, done, error, mem_chipselect, mem_write, mem_clken;
  logic          out_valid, out_sop, out_eop;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic [DW-1:0] mem_readdata, out_data;
`ifdef MEM_READER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif
  logic [31:0]   mem [0:32767];
  int            total = 0, bad = 0, cyc = 0;
  int            cs_n = 0, hs_n = 0, valid_n = 0, done_n = 0, viol_n = 0, stab_n = 0, occ = 0;
  logic [31:0]   q_data[$];
  bit            q_sop[$], q_eop[$];
  int            q_cyc[$];
  logic          prev_stall = 1'b0, prev_sop, prev_eop;
  logic [31:0]   prev_data;

  onchip_mem_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .error(error), .mem_address(mem_address),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_byteenable(mem_byteenable),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop)
`ifdef MEM_READER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_chipselect) mem_readdata <= mem[mem_address];

  always @(negedge clk) begin
    if (mem_chipselect) cs_n++;
    if (out_valid) valid_n++;
    if (done) done_n++;
    if (prev_stall && (out_data !== prev_data || out_sop !== prev_sop || out_eop !== prev_eop)) stab_n++;
    prev_stall = out_valid && !out_ready && !reset;
    prev_data  = out_data;
    prev_sop   = out_sop;
    prev_eop   = out_eop;
    if (reset) occ = 0;
    else begin
      if (mem_chipselect && occ - int'(out_valid && out_ready) >= 2) viol_n++;
      occ = occ + int'(mem_chipselect) - int'(out_valid && out_ready);
    end
    if (out_valid && out_ready) begin
      hs_n++;
      q_data.push_back(out_data);
      q_sop.push_back(out_sop);
      q_eop.push_back(out_eop);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int s_cyc;
  task automatic go(input logic [AW-1:0] b, input logic [CW-1:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    s_cyc      = cyc;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, done}, 32'd1);
  endtask

  initial begin
    int b, cs0, v0, d0, h0, n;
    for (int i = 0; i < 32768; i++) mem[i] = i;
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_error", {31'b0, error}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_cs", {31'b0, mem_chipselect}, 0);
    chk("rst_addr", {17'b0, mem_address}, 0);
    chk("rst_be", {28'b0, mem_byteenable}, 32'hF);
    chk("rst_clken", {31'b0, mem_clken}, 1);
    chk("rst_write", {31'b0, mem_write}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sopeop", {30'b0, out_sop, out_eop}, 0);
    reset = 1'b0;
    tick();

    out_ready = 1'b1;
    b = q_data.size();
    go(15'h0010, 16'd4);
    chk("t1_busy_t1", {31'b0, busy}, 1);
    chk("t1_cs_t1", {31'b0, mem_chipselect}, 1);
    chk("t1_addr_t1", {17'b0, mem_address}, 32'h10);
    wait_done("t1_done");
    chk("t1_busy_at_done", {31'b0, busy}, 0);
    chk("t1_count", q_data.size() - b, 4);
    if (q_data.size() - b == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t1_data%0d", i), q_data[b+i], 32'h10 + i);
        chk($sformatf("t1_sop%0d", i), {31'b0, q_sop[b+i]}, {31'b0, i == 0});
        chk($sformatf("t1_eop%0d", i), {31'b0, q_eop[b+i]}, {31'b0, i == 3});
        chk($sformatf("t1_cyc%0d", i), q_cyc[b+i], s_cyc + 3 + i);
      end
      chk("t1_done_cyc", cyc, q_cyc[b+3] + 1);
    end
    tick();
    chk("t1_done_pulse", {31'b0, done}, 0);

    b = q_data.size();
    cs0 = cs_n;
    go(15'h0100, 16'd8);
    n = 0;
    while (!done && n < 300) begin
      if (n == 4) chk("t2_start_busy_no_err", {31'b0, error}, 0);
      out_ready = ~out_ready;
      if (n == 3) begin
        base_addr  = 15'h0;
        word_count = 16'd0;
      end
      start = (n == 3);
      tick();
      n++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("t2_done", {31'b0, done}, 1);
    chk("t2_count", q_data.size() - b, 8);
    if (q_data.size() - b == 8) begin
      for (int i = 0; i < 8; i++) chk($sformatf("t2_data%0d", i), q_data[b+i], 32'h100 + i);
      chk("t2_sop", {31'b0, q_sop[b]}, 1);
      chk("t2_eop", {31'b0, q_eop[b+7]}, 1);
      chk("t2_mid_flags", {30'b0, q_sop[b+4], q_eop[b+4]}, 0);
      chk("t2_spread", {31'b0, q_cyc[b+7] - q_cyc[b] >= 14}, 1);
    end
    chk("t2_reads", cs_n - cs0, 8);
    chk("t2_credit_viol", viol_n, 0);
    chk("t2_stable", stab_n, 0);
    tick();

    cs0 = cs_n;
    v0 = valid_n;
    go(15'h0050, 16'd0);
    chk("t3_zero_done", {31'b0, done}, 1);
    chk("t3_zero_busy", {31'b0, busy}, 0);
    tick();
    chk("t3_zero_done_pulse", {31'b0, done}, 0);
    repeat (3) tick();
    chk("t3_zero_no_reads", cs_n - cs0, 0);
    chk("t3_zero_no_valid", valid_n - v0, 0);
    go(15'd32030, 16'd7);
    chk("t3_err_pulse", {31'b0, error}, 1);
    chk("t3_err_busy", {31'b0, busy}, 0);
    tick();
    chk("t3_err_clear", {31'b0, error}, 0);
    chk("t3_err_busy2", {31'b0, busy}, 0);
    chk("t3_err_no_cs", {31'b0, mem_chipselect}, 0);
    b = q_data.size();
    go(15'd32030, 16'd6);
    chk("t3_edge_busy", {31'b0, busy}, 1);
    chk("t3_edge_err", {31'b0, error}, 0);
    wait_done("t3_edge_done");
    chk("t3_edge_count", q_data.size() - b, 6);
    if (q_data.size() - b == 6) chk("t3_edge_last", q_data[b+5], 32'd32035);
    tick();

    h0 = hs_n;
    go(15'h0300, 16'd10);
    n = 0;
    while (hs_n - h0 < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("t4_three_words", {31'b0, hs_n - h0 >= 3}, 1);
    reset = 1'b1;
    tick();
    chk("t4_rst_busy", {31'b0, busy}, 0);
    chk("t4_rst_done", {31'b0, done}, 0);
    chk("t4_rst_valid", {31'b0, out_valid}, 0);
    chk("t4_rst_cs", {31'b0, mem_chipselect}, 0);
    chk("t4_rst_addr", {17'b0, mem_address}, 0);
    chk("t4_rst_sopeop", {30'b0, out_sop, out_eop}, 0);
    reset = 1'b0;
    d0 = done_n;
    v0 = valid_n;
    repeat (4) tick();
    chk("t4_no_done", done_n - d0, 0);
    chk("t4_no_stale", valid_n - v0, 0);
    b = q_data.size();
    go(15'h0020, 16'd2);
    wait_done("t4_restart_done");
    chk("t4_restart_count", q_data.size() - b, 2);
    if (q_data.size() - b == 2) begin
      chk("t4_restart_d0", q_data[b], 32'h20);
      chk("t4_restart_d1", q_data[b+1], 32'h21);
      chk("t4_restart_flags", {28'b0, q_sop[b], q_eop[b], q_sop[b+1], q_eop[b+1]}, 32'b1001);
    end
    tick();

`ifdef MEM_READER_CHECKSUM_EN
    mem[32'h200] = 32'd1;
    mem[32'h201] = 32'd2;
    mem[32'h202] = 32'd3;
    mem[32'h203] = 32'hFFFF_FFFF;
    go(15'h0200, 16'd4);
    chk("cs_cleared", checksum, 0);
    wait_done("cs_done");
    chk("cs_value", checksum, 32'd5);
    repeat (2) tick();
    chk("cs_hold", checksum, 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
